// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register fused with the data-memory access controller.
// Loads and stores run a req/ack handshake and hold the upstream stages until completion.
module mem_access_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            WB_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [DATA_W-1:0]     ALUResult_i,
    input  logic [DATA_W-1:0]     WriteData_i,
    input  logic [REG_ADDR_W-1:0] RegAddr_i,
    output logic [1:0]            WB_o,
    output logic [DATA_W-1:0]     ReadData_o,
    output logic [DATA_W-1:0]     ALUResult_o,
    output logic [REG_ADDR_W-1:0] RegAddr_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // The counter only has to reach TIMEOUT-1: the abort fires on the edge that would make it TIMEOUT.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TO_EN    = (TIMEOUT > 0);

    state_t                  state;
    logic [1:0]              wb_p1;
    logic                    memwrite_p1;
    logic [DATA_W-1:0]       alu_p1;
    logic [DATA_W-1:0]       wdata_p1;
    logic [REG_ADDR_W-1:0]   rd_p1;
    logic [DATA_W-1:0]       rdata_p1;
    logic                    err_p1;
    logic [CNT_W-1:0]        cnt_p1;

    function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    // EX -> MEM capture and access sequencing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wb_p1       <= '0;
            memwrite_p1 <= 1'b0;
            alu_p1      <= '0;
            wdata_p1    <= '0;
            rd_p1       <= '0;
            rdata_p1    <= '0;
            err_p1      <= 1'b0;
            cnt_p1      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    alu_p1      <= ALUResult_i;
                    wdata_p1    <= WriteData_i;
                    rd_p1       <= RegAddr_i;
                    memwrite_p1 <= MemWrite_i;
                    rdata_p1    <= '0;
                    cnt_p1      <= '0;
                    if (MemRead_i || MemWrite_i) begin
                        if (is_word_aligned(ALUResult_i)) begin
                            wb_p1 <= WB_i;
                            state <= ACCESS;
                        end else begin
                            // Misaligned access is squashed into a bubble, never reaches memory.
                            wb_p1  <= 2'b00;
                            err_p1 <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        wb_p1 <= WB_i;
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        if (!memwrite_p1) begin
                            rdata_p1 <= mem_rdata_i;
                        end
                        state <= DONE;
                    end else if (TO_EN && (cnt_p1 == CNT_LAST)) begin
                        wb_p1  <= 2'b00;
                        err_p1 <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt_p1 <= cnt_p1 + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM -> WB outputs, decoded from registered state only
    assign stall_o     = (state == ACCESS);
    assign mem_req_o   = (state == ACCESS);
    assign mem_we_o    = (state == ACCESS) && memwrite_p1;
    assign mem_addr_o  = alu_p1;
    assign mem_wdata_o = wdata_p1;
    assign WB_o        = (state == ACCESS) ? 2'b00 : wb_p1;
    assign ReadData_o  = rdata_p1;
    assign ALUResult_o = alu_p1;
    assign RegAddr_o   = rd_p1;
    assign err_o       = err_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cycles push expected outputs,
// a monitor pops one record per clock and compares against the DUT.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_in;
    logic        mr, mw;
    logic [31:0] alu_in, wd_in;
    logic [4:0]  rd_in;
    logic        ack;
    logic [31:0] rdata_in;

    logic [1:0]  WB_o;
    logic [31:0] ReadData_o, ALUResult_o, mem_addr_o, mem_wdata_o;
    logic [4:0]  RegAddr_o;
    logic        stall_o, mem_req_o, mem_we_o, err_o;

    typedef struct {
        string       name;
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_access_stage #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .WB_i(wb_in), .MemRead_i(mr), .MemWrite_i(mw),
        .ALUResult_i(alu_in), .WriteData_i(wd_in), .RegAddr_i(rd_in),
        .WB_o(WB_o), .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .RegAddr_o(RegAddr_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(ack), .mem_rdata_i(rdata_in), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic [1:0] w, input logic rdf, input logic wrf,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rg,
                          input logic ak, input logic [31:0] rdat);
        rst = r; wb_in = w; mr = rdf; mw = wrf; alu_in = a; wd_in = d; rd_in = rg;
        ack = ak; rdata_in = rdat;
    endtask

    task automatic push(input string name, input logic [1:0] w, input logic [31:0] rdat,
                        input logic [31:0] a, input logic [4:0] rg, input logic st,
                        input logic rq, input logic we, input logic [31:0] wdat, input logic er);
        exp_t e;
        e.name = name; e.wb = w; e.rdata = rdat; e.alu = a; e.rd = rg;
        e.stall = st; e.req = rq; e.we = we; e.wdata = wdat; e.err = er;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic exp_out(input string name, input logic [1:0] w, input logic [31:0] rdat,
                           input logic [31:0] a, input logic [4:0] rg, input logic er);
        push(name, w, rdat, a, rg, 1'b0, 1'b0, 1'b0, 32'h0, er);
    endtask

    task automatic exp_acc(input string name, input logic [31:0] a, input logic [4:0] rg,
                           input logic we, input logic [31:0] wdat, input logic er);
        push(name, 2'b00, 32'h0, a, rg, 1'b1, 1'b1, we, wdat, er);
    endtask

    // Monitor: one expected record per clock, sampled shortly after the edge
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            bad = (WB_o !== e.wb) || (ReadData_o !== e.rdata) || (ALUResult_o !== e.alu) ||
                  (RegAddr_o !== e.rd) || (stall_o !== e.stall) || (mem_req_o !== e.req) ||
                  (mem_we_o !== e.we) || (err_o !== e.err) ||
                  (e.req && ((mem_addr_o !== e.alu) || (mem_wdata_o !== e.wdata)));
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s (got/exp): wb=%b/%b rdata=%h/%h alu=%h/%h rd=%0d/%0d stall=%b/%b req=%b/%b we=%b/%b addr=%h/%h wdata=%h/%h err=%b/%b",
                         e.name, WB_o, e.wb, ReadData_o, e.rdata, ALUResult_o, e.alu,
                         RegAddr_o, e.rd, stall_o, e.stall, mem_req_o, e.req, mem_we_o, e.we,
                         mem_addr_o, e.alu, mem_wdata_o, e.wdata, err_o, e.err);
            end
        end
    end

    initial begin
        set_in(1, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        @(negedge clk);

        // reset and a plain ALU instruction
        exp_out("reset", 2'b00, 32'h0, 32'h0, 5'd0, 0);
        set_in(0, 2'b10, 0, 0, 32'h5, 32'h0, 5'd3, 0, 32'h0);
        exp_out("add", 2'b10, 32'h0, 32'h5, 5'd3, 0);

        // lw 0x10, acked in the third access cycle; inputs during ACCESS are junk
        set_in(0, 2'b11, 1, 0, 32'h10, 32'h0, 5'd8, 0, 32'h0);
        exp_acc("lw_acc1", 32'h10, 5'd8, 0, 32'h0, 0);
        set_in(0, 2'b01, 0, 1, 32'hFFFF_FFF0, 32'hBAD0_BAD0, 5'd31, 0, 32'h1111_1111);
        exp_acc("lw_acc2", 32'h10, 5'd8, 0, 32'h0, 0);
        exp_acc("lw_acc3", 32'h10, 5'd8, 0, 32'h0, 0);
        set_in(0, 2'b01, 0, 1, 32'hFFFF_FFF0, 32'hBAD0_BAD0, 5'd31, 1, 32'hDEAD_BEEF);
        exp_out("lw_done", 2'b11, 32'hDEAD_BEEF, 32'h10, 5'd8, 0);

        // sw 0x20 captured straight from DONE, acked on the first access cycle
        set_in(0, 2'b00, 0, 1, 32'h20, 32'h1234_5678, 5'd0, 0, 32'h0);
        exp_acc("sw_acc", 32'h20, 5'd0, 1, 32'h1234_5678, 0);
        set_in(0, 2'b11, 1, 0, 32'h99, 32'h0, 5'd2, 1, 32'hAAAA_5555);
        exp_out("sw_done", 2'b00, 32'h0, 32'h20, 5'd0, 0);

        // misaligned lw, then sticky error and stray ack
        set_in(0, 2'b11, 1, 0, 32'h13, 32'h0, 5'd9, 0, 32'h0);
        exp_out("lw_misalign", 2'b00, 32'h0, 32'h13, 5'd9, 1);
        set_in(0, 2'b10, 0, 0, 32'h7, 32'h0, 5'd4, 0, 32'h0);
        exp_out("err_sticky", 2'b10, 32'h0, 32'h7, 5'd4, 1);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h7777_7777);
        exp_out("stray_ack", 2'b00, 32'h0, 32'h0, 5'd0, 1);
        set_in(1, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_out("reset2", 2'b00, 32'h0, 32'h0, 5'd0, 0);

        // timeout: four access cycles without ack, then abort
        set_in(0, 2'b11, 1, 0, 32'h40, 32'h0, 5'd5, 0, 32'h0);
        exp_acc("to_acc1", 32'h40, 5'd5, 0, 32'h0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_acc("to_acc2", 32'h40, 5'd5, 0, 32'h0, 0);
        exp_acc("to_acc3", 32'h40, 5'd5, 0, 32'h0, 0);
        exp_acc("to_acc4", 32'h40, 5'd5, 0, 32'h0, 0);
        exp_out("to_abort", 2'b00, 32'h0, 32'h40, 5'd5, 1);
        set_in(1, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_out("reset3", 2'b00, 32'h0, 32'h0, 5'd0, 0);

        // ack arriving on the very cycle the timeout would fire wins
        set_in(0, 2'b11, 1, 0, 32'h44, 32'h0, 5'd6, 0, 32'h0);
        exp_acc("edge_acc1", 32'h44, 5'd6, 0, 32'h0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_acc("edge_acc2", 32'h44, 5'd6, 0, 32'h0, 0);
        exp_acc("edge_acc3", 32'h44, 5'd6, 0, 32'h0, 0);
        exp_acc("edge_acc4", 32'h44, 5'd6, 0, 32'h0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hCAFE_F00D);
        exp_out("edge_ack", 2'b11, 32'hCAFE_F00D, 32'h44, 5'd6, 0);

        // reset in the second access cycle, late ack afterwards is ignored
        set_in(0, 2'b11, 1, 0, 32'h50, 32'h0, 5'd7, 0, 32'h0);
        exp_acc("rst_acc1", 32'h50, 5'd7, 0, 32'h0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_acc("rst_acc2", 32'h50, 5'd7, 0, 32'h0, 0);
        set_in(1, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_out("rst_mid", 2'b00, 32'h0, 32'h0, 5'd0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h55AA_55AA);
        exp_out("late_ack", 2'b00, 32'h0, 32'h0, 5'd0, 0);
        set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        exp_out("idle", 2'b00, 32'h0, 32'h0, 5'd0, 0);

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, 0 required", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- EX/MEM pipeline register merged with the data-memory access controller of the 5-stage MIPS pipeline.
- Captures the EX-stage result, runs a load or store against a variable-latency data memory using a req/ack handshake, and stalls the upstream stages until the access completes.
- Drives the MEM/WB register directly: WB control bits, read data, ALU result and destination register.

Parameters:
- DATA_W, 32, width of data, address and ALU result.
- REG_ADDR_W, 5, width of the destination register number.
- TIMEOUT, 255, maximum cycles waiting for mem_ack_i before the access is aborted; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- WB_i  in  2  [1]=RegWrite, [0]=MemToReg from the ID/EX register.
- MemRead_i  in  1  instruction is a load.
- MemWrite_i  in  1  instruction is a store.
- ALUResult_i  in  DATA_W  ALU result; memory address for lw/sw.
- WriteData_i  in  DATA_W  store data (rt value after forwarding).
- RegAddr_i  in  REG_ADDR_W  destination register.
- WB_o  out  2  to MEM/WB; 2'b00 means bubble.
- ReadData_o  out  DATA_W  load data to MEM/WB.
- ALUResult_o  out  DATA_W  ALU result to MEM/WB.
- RegAddr_o  out  REG_ADDR_W  destination register to MEM/WB.
- stall_o  out  1  freezes PC, IF/ID and ID/EX when high.
- mem_req_o  out  1  data-memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  DATA_W  word-aligned address.
- mem_wdata_o  out  DATA_W  store data.
- mem_ack_i  in  1  memory completes the access in this cycle.
- mem_rdata_i  in  DATA_W  read data, valid while mem_ack_i=1.
- err_o  out  1  sticky error flag (misaligned access or timeout).

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (rst_i=1 at a posedge) forces, from any state including mid-ACCESS:
  - state=IDLE, and all captured registers and outputs zero;
  - WB_o=00, stall_o=0, mem_req_o=0, mem_we_o=0, err_o=0, timeout counter=0.
  - An outstanding memory transaction is abandoned; an ack arriving after reset is ignored.
- Capture: at a posedge with state IDLE or DONE, all *_i inputs are registered.
  - Inputs are ignored while in ACCESS, because upstream is frozen.
- Non-memory instruction (MemRead_i=MemWrite_i=0):
  - next state IDLE;
  - outputs reflect the captured values one cycle after capture;
  - ReadData_o=0.
- Memory instruction with ALUResult_i[1:0]==0:
  - next state ACCESS.
  - In ACCESS: mem_req_o=1, held stable together with mem_we_o (=captured MemWrite), mem_addr_o and mem_wdata_o until ack.
  - In ACCESS: stall_o=1 and WB_o=00, so MEM/WB sees a bubble.
- mem_ack_i=1 sampled at a posedge while in ACCESS:
  - mem_rdata_i is registered into ReadData_o for loads; stores leave ReadData_o at 0;
  - state becomes DONE.
  - In DONE: mem_req_o=0, stall_o=0, and WB_o = captured WB.
  - Total latency = ack latency + 1 cycle.
- mem_ack_i outside ACCESS is ignored.
- Misaligned memory instruction (ALUResult_i[1:0]!=0):
  - no request is issued; next state IDLE;
  - WB_o forced to 00 for that instruction;
  - err_o set.
- Timeout (TIMEOUT>0):
  - counter clears on entry to ACCESS and increments each ACCESS cycle without ack;
  - when the count reaches TIMEOUT with no ack: abort to DONE with WB_o=00, ReadData_o=0, err_o set.
  - An ack in the same cycle as count==TIMEOUT wins: normal completion, no error.
- err_o stays high until reset.
- stall_o and mem_req_o are decoded from the registered state only; there is no combinational path from mem_ack_i.
- Back-to-back memory operations: DONE captures the next instruction; if it is a memory op, the next state is ACCESS directly.

Test Plan:
- Reset, then capture add: WB_i=10, ALUResult_i=0x0000_0005, RegAddr_i=3 -> next cycle WB_o=10, ALUResult_o=5, RegAddr_o=3; stall_o and mem_req_o stay 0.
- lw at 0x0000_0010, WB_i=11, memory acks 3 cycles after the request with rdata 0xDEAD_BEEF:
  - stall_o=1 and WB_o=00 for 3 cycles, mem_we_o=0;
  - then DONE with WB_o=11 and ReadData_o=0xDEAD_BEEF.
- sw at 0x20, data 0x1234_5678, ack on the first ACCESS cycle -> mem_we_o=1, addr 0x20, wdata 0x1234_5678; DONE with WB_o=00 and ReadData_o=0.
- lw at 0x0000_0013 -> no mem_req_o; WB_o=00; err_o=1 and remains 1 across later instructions.
- TIMEOUT=4, lw, ack never asserted -> 4 ACCESS cycles, then DONE with WB_o=00 and err_o=1; repeat with ack asserted exactly at count 4 -> normal completion, err_o=0.
- rst_i asserted in the 2nd ACCESS cycle, then an ack arrives one cycle later -> state IDLE with all outputs 0; the late ack causes no change.
